uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that consumes the serial line produced by the team's uart_tx. It converts 8N1 frames into parallel bytes: 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1). Each received byte is presented with a single-cycle valid strobe. The block sits between the FPGA rx pin and the fault-injection command/loopback logic, and flags framing errors for campaign logging.

Parameters:
BAUD_RATE, 115200, line bit rate.
CLOCK_FREQ, 50000000, clk frequency in Hz.
TICKS_PER_BIT, CLOCK_FREQ / BAUD_RATE (434), clk cycles per bit period.
HALF_BIT, TICKS_PER_BIT / 2 (217), delay from the detected start edge to the start-bit sample.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
rx  input  1  asynchronous serial input; idles high.
data  output  8  last correctly framed byte; holds its value between frames.
valid  output  1  one-cycle pulse; data is updated in the same cycle.
frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Synchroniser: rx passes through 2 flops to give rx_s. Both flops reset to 1. All decisions use rx_s only.
- Counters:
  - tick counter: 16 bits, unsigned.
  - bit index: 3 bits.
  - shift register: 8 bits, filled by shifting right, with the new bit entering at bit 7.
- Reset values: data=0x00, valid=0, frame_err=0, busy=0, state=IDLE, counters=0.
- Reset mid-frame: the partial byte is discarded, no valid or frame_err is raised, and the FSM returns to IDLE.
- IDLE: when rx_s==0, go to START with tick=0. busy rises on the next cycle.
- START: increment tick. At tick==HALF_BIT-1, sample rx_s:
  - rx_s==1: glitch or false start; return to IDLE with no output pulse.
  - rx_s==0: go to DATA with tick=0 and bit index=0.
- DATA: at tick==TICKS_PER_BIT-1, sample rx_s into the shift register and set tick=0.
  - After the 8th sample (bit index==7), go to STOP.
  - Otherwise increment bit index.
- STOP: at tick==TICKS_PER_BIT-1, sample rx_s:
  - rx_s==1: on the next clock, data<=shift register and valid=1 for exactly 1 cycle. Then go to IDLE.
  - rx_s==0: frame_err=1 for exactly 1 cycle and data is NOT updated. Then go to BREAK_WAIT.
- BREAK_WAIT: remain here until rx_s==1, then go to IDLE. A line held low (break) therefore produces exactly one frame_err and no spurious frames.
- valid and frame_err are never high in the same cycle.
- Latency: valid rises 2 + HALF_BIT + 9*TICKS_PER_BIT + 1 cycles (±1) after the rx falling edge of the start bit.
- Back-to-back frames: the FSM is back in IDLE at mid-stop-bit, so a new start edge immediately after the stop bit is accepted. No idle gap is required.
- No output buffering: the consumer must take data within one frame time. There is no overrun flag; a new byte simply overwrites data.
- Tolerance: mid-bit sampling must decode correctly with sender bit periods from TICKS_PER_BIT-17 to TICKS_PER_BIT+17 cycles (about ±4%). This covers the transmitter's TICKS_PER_BIT+1-cycle bit period.

Test Plan:
1. Reset, then drive frame 0x55 with 434-cycle bits -> exactly one valid pulse, data==0x55, frame_err never high, busy low after the frame.
2. rx low pulse of 100 cycles, then high -> no valid, no frame_err, FSM back in IDLE (busy low) within HALF_BIT+3 cycles.
3. Frame 0xA7 with a stop bit of 0, rx held low 5000 cycles, then high, then frame 0x12 -> one frame_err pulse, data stays 0x00 during the error, then valid with data==0x12.
4. Back-to-back frames 0xA5, 0x3C, 0xFF, 0x00 with no idle gap -> four valid pulses in order with matching data, spaced 10*434 ±2 cycles apart.
5. Bit period 451 cycles, byte 0xC3; then bit period 417 cycles, byte 0x81 -> both decoded correctly with no frame_err. Also loop uart_tx output into rx with data=0x5A -> repeated valid with data==0x5A.
6. Assert rst for 1 cycle during data bit 4 of frame 0x99, then send 0x42 -> no valid for the aborted frame, outputs at reset values, next valid has data==0x42.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of uart_rx.
// master is the receiver side, slave is the consuming logic.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   modport master (
      input  rx,
      output data, valid, frame_err, busy
   );

   modport slave (
      output rx,
      input  data, valid, frame_err, busy
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling.
// Emits one-cycle valid per good byte, frame_err on a bad stop bit.
module uart_rx #(
   parameter int BAUD_RATE  = 115200,
   parameter int CLOCK_FREQ = 50000000
) (
   input logic       clk,
   input logic       rst,
   uart_rx_if.master bus
);
   localparam int TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF_BIT      = TICKS_PER_BIT / 2;
   localparam logic [15:0] TICK_BIT  = 16'(TICKS_PER_BIT - 1);
   localparam logic [15:0] TICK_HALF = 16'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, BREAK_WAIT
   } state_t;

   state_t      state, state_d;
   logic        rx_meta, rx_s;
   logic [15:0] tick, tick_d;
   logic [2:0]  bit_idx, bit_d;
   logic [7:0]  shreg, shreg_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;

   // two-flop synchroniser; idle-high line so both reset to 1
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   // state, counters and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tick    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_d;
         tick    <= tick_d;
         bit_idx <= bit_d;
         shreg   <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // next-state: start qualify, mid-bit sampling, stop check
   always_comb begin
      state_d = state;
      tick_d  = tick;
      bit_d   = bit_idx;
      shreg_d = shreg;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               tick_d  = '0;
            end
         end
         START: begin
            if (tick == TICK_HALF) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               tick_d = tick + 16'd1;
            end
         end
         DATA: begin
            if (tick == TICK_BIT) begin
               tick_d  = '0;
               shreg_d = {rx_s, shreg[7:1]};
               if (bit_idx == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_idx + 3'd1;
               end
            end else begin
               tick_d = tick + 16'd1;
            end
         end
         STOP: begin
            if (tick == TICK_BIT) begin
               tick_d = '0;
               if (rx_s) begin
                  valid_d = 1'b1;
                  data_d  = shreg;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK_WAIT;
               end
            end else begin
               tick_d = tick + 16'd1;
            end
         end
         BREAK_WAIT: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table, hand-written and random frames against uart_rx.
// Expected bytes come from a sample-point model of the 8N1 line.
module tb_uart_rx;
   localparam int TPB  = 434;
   localparam int HALF = 217;
   localparam int LAT  = 2 + HALF + 9 * TPB + 1;

   typedef struct {
      logic [7:0] d;
      int         period;
      logic       stop;
      int         exp_valid;
      int         exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   pass_n = 0;
   int   total_n = 0;
   int   err_n = 0;
   int   both_n = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] got_q[$];
   int         got_t[$];
   vec_t       tbl[7];

   uart_rx_if u_if ();

   uart_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // record every output pulse observed away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (u_if.valid) begin
            got_q.push_back(u_if.data);
            got_t.push_back(cyc);
         end
         if (u_if.frame_err) err_n++;
         if (u_if.valid && u_if.frame_err) both_n++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total_n++;
      if (act == exp) pass_n++;
      else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                    name, act, act, exp, exp);
   endtask

   task automatic hold(input logic v, input int n);
      u_if.rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int p,
                             input logic stop);
      hold(1'b0, p);
      for (int i = 0; i < 8; i++) hold(d[i], p);
      hold(stop, p);
   endtask

   // value seen at each nominal mid-bit point of a frame sent at period p
   function automatic logic [8:0] model(input logic [7:0] d, input int p,
                                        input logic stop);
      logic [9:0] fr;
      logic [8:0] r;
      int idx;
      fr = {stop, d, 1'b0};
      for (int k = 1; k <= 9; k++) begin
         idx = (HALF + k * TPB + 3) / p;
         r[k-1] = (idx <= 9) ? fr[idx] : 1'b1;
      end
      return r;
   endfunction

   task automatic run_row(input logic [7:0] d, input int p, input logic stop,
                          input int ev, input int ee, input logic [7:0] eb);
      int t0;
      got_q.delete();
      got_t.delete();
      err_n = 0;
      t0 = cyc;
      send_frame(d, p, stop);
      if (!stop) begin
         hold(1'b0, 5000);
         check("break_busy", int'(u_if.busy), 1);
         check("break_data", int'(u_if.data), int'(last_data));
      end
      hold(1'b1, 30);
      check("valid_count", got_q.size(), ev);
      check("err_count", err_n, ee);
      check("busy_after", int'(u_if.busy), 0);
      if (ev == 1 && got_q.size() > 0) begin
         check("byte", int'(got_q[0]), int'(eb));
         last_data = eb;
         if (p == TPB) begin
            t0 = got_t[0] - t0 - LAT;
            check("latency_ok", int'(t0 >= -1 && t0 <= 1), 1);
         end
      end
      check("data_reg", int'(u_if.data), int'(last_data));
   endtask

   initial begin
      logic [8:0] m;
      logic [7:0] rd;
      int rp;
      logic [7:0] b2b[4];
      logic [7:0] r99;

      u_if.rx = 1'b1;
      tbl[0] = '{8'hA7, 434, 1'b0, 0, 1};
      tbl[1] = '{8'h12, 434, 1'b1, 1, 0};
      tbl[2] = '{8'h55, 434, 1'b1, 1, 0};
      tbl[3] = '{8'hC3, 451, 1'b1, 1, 0};
      tbl[4] = '{8'h81, 417, 1'b1, 1, 0};
      tbl[5] = '{8'h5A, 435, 1'b1, 1, 0};
      tbl[6] = '{8'h5A, 435, 1'b1, 1, 0};

      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_data", int'(u_if.data), 0);
      check("rst_valid", int'(u_if.valid), 0);
      check("rst_ferr", int'(u_if.frame_err), 0);
      check("rst_busy", int'(u_if.busy), 0);
      hold(1'b1, 20);

      for (int i = 0; i < 7; i++) begin
         run_row(tbl[i].d, tbl[i].period, tbl[i].stop,
                 tbl[i].exp_valid, tbl[i].exp_err, tbl[i].d);
      end

      // short low glitch must be rejected at the start-bit sample
      got_q.delete();
      err_n = 0;
      hold(1'b0, 100);
      check("glitch_busy", int'(u_if.busy), 1);
      hold(1'b1, HALF + 3 - 100);
      check("glitch_idle", int'(u_if.busy), 0);
      hold(1'b1, 50);
      check("glitch_valid", got_q.size(), 0);
      check("glitch_err", err_n, 0);

      // back-to-back frames with no idle gap
      b2b[0] = 8'hA5;
      b2b[1] = 8'h3C;
      b2b[2] = 8'hFF;
      b2b[3] = 8'h00;
      got_q.delete();
      got_t.delete();
      err_n = 0;
      for (int i = 0; i < 4; i++) send_frame(b2b[i], TPB, 1'b1);
      hold(1'b1, 30);
      check("b2b_count", got_q.size(), 4);
      check("b2b_err", err_n, 0);
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         check("b2b_byte", int'(got_q[i]), int'(b2b[i]));
         if (i > 0) begin
            rp = got_t[i] - got_t[i-1] - 10 * TPB;
            check("b2b_spacing_ok", int'(rp >= -2 && rp <= 2), 1);
         end
      end
      last_data = 8'h00;

      // reset in the middle of data bit 4 of 0x99
      r99 = 8'h99;
      got_q.delete();
      err_n = 0;
      hold(1'b0, TPB);
      for (int i = 0; i < 4; i++) hold(r99[i], TPB);
      hold(r99[4], 200);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_data", int'(u_if.data), 0);
      check("mid_rst_valid", int'(u_if.valid), 0);
      check("mid_rst_ferr", int'(u_if.frame_err), 0);
      check("mid_rst_busy", int'(u_if.busy), 0);
      last_data = 8'h00;
      hold(1'b1, 500);
      check("mid_rst_noval", got_q.size(), 0);
      run_row(8'h42, TPB, 1'b1, 1, 0, 8'h42);

      // random bytes at random in-tolerance bit periods
      for (int i = 0; i < 2; i++) begin
         rd = 8'($urandom);
         rp = int'($urandom_range(TPB + 17, TPB - 17));
         m = model(rd, rp, 1'b1);
         run_row(rd, rp, 1'b1, int'(m[8]), int'(!m[8]), m[7:0]);
      end

      check("valid_and_err", both_n, 0);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
